// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage in front of the opcode decoder. Owns the PC, runs
//   a req/ready handshake to instruction memory and holds one fetched
//   instruction in the IF/ID register. Handles branch/jump redirects and
//   parks in HALT after fetching a HALT opcode (5'b00000).
//
//   Optional feature: define FETCH_SKID_EN to add a one-entry skid buffer
//   that keeps a response that arrives while the IF/ID slot is busy, instead
//   of discarding it and fetching the same address again.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   o_imem_req     memory request, high only in REQ
//   o_imem_addr    request address (= pc), stable while o_imem_req=1
//   i_imem_ready   response valid this cycle
//   i_imem_rdata   fetched instruction
//   i_redirect     taken branch/jump from downstream, highest priority
//   i_redirect_pc  new fetch address
//   i_stall        decode cannot accept the held instruction this cycle
//   o_if_valid     IF/ID register holds a live instruction
//   o_if_instr     held instruction
//   o_if_pc        address of o_if_instr
//   o_if_pc_inc    o_if_pc + 2 (link / branch base)
//   o_opcode       o_if_instr[15:11], feeds the decoder
//   o_halted       high in HALT
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_ready,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    input  logic               i_stall,
    output logic               o_if_valid,
    output logic [INSTR_W-1:0] o_if_instr,
    output logic [PC_W-1:0]    o_if_pc,
    output logic [PC_W-1:0]    o_if_pc_inc,
    output logic [4:0]         o_opcode,
    output logic               o_halted
);

    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'h0800);
    localparam logic [4:0]         OP_HALT   = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [PC_W-1:0]    r_if_pc;

    logic               w_consume;
    logic               w_slot_free;
    logic               w_rdata_halt;
    logic               w_load;
    logic               w_pc_adv;
    logic               w_skid_valid;

`ifdef FETCH_SKID_EN
    logic               r_skid_valid;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;
    logic               w_skid_cap;

    assign w_skid_valid = r_skid_valid;
`else
    assign w_skid_valid = 1'b0;
`endif

    assign w_consume    = r_if_valid && !i_stall;
    assign w_slot_free  = !r_if_valid || w_consume;
    assign w_rdata_halt = (i_imem_rdata[INSTR_W-1 -: 5] == OP_HALT);

    // Next-state and datapath strobes. Redirect is applied last so it
    // overrides every load, PC advance and state change decided above it.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pc_adv    = 1'b0;
`ifdef FETCH_SKID_EN
        w_skid_cap  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // A pending skid entry must drain before the next fetch
                if (w_slot_free && !w_skid_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_imem_ready) begin
                    if (w_slot_free) begin
                        w_load      = 1'b1;
                        w_pc_adv    = 1'b1;
                        w_state_nxt = w_rdata_halt ? ST_HALT : ST_IDLE;
                    end else begin
`ifdef FETCH_SKID_EN
                        w_skid_cap  = 1'b1;
                        w_pc_adv    = 1'b1;
                        w_state_nxt = w_rdata_halt ? ST_HALT : ST_IDLE;
`else
                        // Response thrown away; pc unchanged so it is re-fetched
                        w_state_nxt = ST_IDLE;
`endif
                    end
                end
            end
            ST_DRAIN: begin
                if (i_imem_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (i_redirect) begin
            w_load   = 1'b0;
            w_pc_adv = 1'b0;
`ifdef FETCH_SKID_EN
            w_skid_cap = 1'b0;
`endif
            // A request already seen by memory still owes a response; wait it out
            if ((r_state == ST_REQ || r_state == ST_DRAIN) && !i_imem_ready) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_redirect_pc;
        end else if (w_pc_adv) begin
            r_pc <= r_pc + PC_W'(2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= '0;
        end else if (i_redirect) begin
            r_if_valid <= 1'b0;
        end else if (w_load) begin
            r_if_valid <= 1'b1;
            r_if_instr <= i_imem_rdata;
            r_if_pc    <= r_pc;
        end else if (w_consume) begin
`ifdef FETCH_SKID_EN
            if (r_skid_valid) begin
                r_if_valid <= 1'b1;
                r_if_instr <= r_skid_instr;
                r_if_pc    <= r_skid_pc;
            end else begin
                r_if_valid <= 1'b0;
            end
`else
            r_if_valid <= 1'b0;
`endif
        end
    end

`ifdef FETCH_SKID_EN
    // Capture only happens with the slot busy (no consume), so it never
    // collides with the skid draining into IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (i_redirect) begin
            r_skid_valid <= 1'b0;
        end else if (w_skid_cap) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= i_imem_rdata;
            r_skid_pc    <= r_pc;
        end else if (w_consume && r_skid_valid) begin
            r_skid_valid <= 1'b0;
        end
    end
`endif

    assign o_imem_req  = (r_state == ST_REQ);
    assign o_imem_addr = r_pc;
    assign o_if_valid  = r_if_valid;
    assign o_if_instr  = r_if_instr;
    assign o_if_pc     = r_if_pc;
    assign o_if_pc_inc = r_if_pc + PC_W'(2);
    assign o_opcode    = r_if_instr[INSTR_W-1 -: 5];
    assign o_halted    = (r_state == ST_HALT);

endmodule
